z80_io_responder: RTL and testbench

- Z80 I/O-space bus responder for the z80 test SoC.
- Decodes IN/OUT cycles driven by chip_z80 and returns wait states on _wait.
- Pushes OUT bytes to a console TX FIFO and serves IN reads from a one-byte RX holding register or a status port.
- Sits beside the RAM model on the same ab/db_i/db_o buses, clocked by eclk.

---
 rtl/z80_io_responder.sv | 181 ++++++++++++++++++
 tb/tb_z80_io_responder.sv | 534 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_responder.sv
// Z80 I/O-space responder: data port feeds a console TX FIFO / RX holding register,
// status/control port at PORT_BASE+1. Define Z80IO_IRQ_EN to add irq_en and the _int output.
module z80_io_responder #(
  parameter logic [7:0] PORT_BASE   = 8'h10,
  parameter int         WAIT_CYCLES = 2,
  parameter int         FIFO_AW     = 3
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic [15:0] ab,
  input  logic [7:0]  db_o,
  output logic [7:0]  db_i,
  output logic        db_oe,
  input  logic        _iorq,
  input  logic        _m1,
  input  logic        _rd,
  input  logic        _wr,
  output logic        _wait,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef Z80IO_IRQ_EN
  ,
  output logic        _int
`endif
);

  // Handshakes: tx byte moves on a cycle where tx_valid && tx_ready; rx byte moves on a
  // cycle where rx_valid && rx_ready. Neither valid may depend on its ready.

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int         DEPTH     = 1 << FIFO_AW;
  localparam logic [7:0] CTRL_PORT = PORT_BASE + 8'd1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]         state;
  logic [3:0]         wait_cnt;
  logic               sel_ctrl;
  logic               is_rd;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               rx_full;
  logic [7:0]         rx_hold;
  logic               irq_en;

  logic               hit;
  logic               data_wr_stall;
  logic               push;
  logic               pop;
  logic               flush;
  logic               rx_pop;
  logic               ctrl_wr;
  logic [7:0]         status;
  logic [7:0]         read_val;
  logic               unused_ab_hi;

  assign unused_ab_hi = ^ab[15:8];

  assign hit = !_iorq && _m1 && (!_rd || !_wr) &&
               ((ab[7:0] == PORT_BASE) || (ab[7:0] == CTRL_PORT));

  // count never exceeds DEPTH, so its top bit alone marks a full FIFO
  assign fifo_full  = count[FIFO_AW];
  assign fifo_empty = (count == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_mem[rd_ptr];
  assign rx_ready   = !rx_full;
  assign _wait      = !((state == ST_WAIT) || (state == ST_ACTIVE));

  assign data_wr_stall = !sel_ctrl && !is_rd && fifo_full;
  assign push    = (state == ST_ACTIVE) && !sel_ctrl && !is_rd && !fifo_full;
  assign pop     = tx_valid && tx_ready;
  assign ctrl_wr = (state == ST_ACTIVE) && sel_ctrl && !is_rd;
  assign flush   = ctrl_wr && db_o[7];
  assign rx_pop  = (state == ST_ACTIVE) && !sel_ctrl && is_rd && rx_full;

  assign status   = {4'b0000, irq_en, fifo_empty, rx_full, !fifo_full};
  assign read_val = sel_ctrl ? status : (rx_full ? rx_hold : 8'hFF);

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      sel_ctrl <= 1'b0;
      is_rd    <= 1'b0;
      db_i     <= 8'h00;
      db_oe    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            sel_ctrl <= (ab[7:0] == CTRL_PORT);
            is_rd    <= !_rd;
            wait_cnt <= WAIT_INIT;
            state    <= (WAIT_INIT == 4'd0) ? ST_ACTIVE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) state <= ST_ACTIVE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_ACTIVE: begin
          if (!data_wr_stall) begin
            state <= ST_HOLD;
            if (is_rd) begin
              db_i  <= read_val;
              db_oe <= 1'b1;
            end
          end
        end
        default: begin
          if (_iorq) begin
            db_oe <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // flush wins over a coincident pop; push and flush never share a cycle
  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge eclk) begin
    if (push) fifo_mem[wr_ptr] <= db_o;
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      rx_full <= 1'b0;
      rx_hold <= 8'h00;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end else if (rx_valid && rx_ready) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end
  end

`ifdef Z80IO_IRQ_EN
  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      irq_en <= 1'b0;
      _int   <= 1'b1;
    end else begin
      if (ctrl_wr) irq_en <= db_o[0];
      _int <= !(irq_en && rx_full);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_z80_io_responder.sv
// Bench for z80_io_responder: directed scenarios plus randomized I/O traffic checked
// against a queue/flag model of the console ports. Covers Z80IO_IRQ_EN when defined.
module tb_z80_io_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int EXP_WAIT    = WAIT_CYCLES + 1;
  localparam int DEPTH       = 8;

`ifdef Z80IO_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        eclk;
  logic        ereset;
  logic [15:0] ab;
  logic [7:0]  db_o;
  logic [7:0]  db_i;
  logic        db_oe;
  logic        _iorq;
  logic        _m1;
  logic        _rd;
  logic        _wr;
  logic        _wait;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
`ifdef Z80IO_IRQ_EN
  logic        _int;
`endif

  int vectors;
  int miscompares;

  // model of the responder's visible state
  logic [7:0] exp_q[$];
  logic       model_rx_full;
  logic [7:0] model_rx;
  logic       model_irq;
  logic [7:0] mon_exp;

  z80_io_responder #(
    .PORT_BASE  (8'h10),
    .WAIT_CYCLES(WAIT_CYCLES),
    .FIFO_AW    (3)
  ) dut (
    .eclk    (eclk),
    .ereset  (ereset),
    .ab      (ab),
    .db_o    (db_o),
    .db_i    (db_i),
    .db_oe   (db_oe),
    ._iorq   (_iorq),
    ._m1     (_m1),
    ._rd     (_rd),
    ._wr     (_wr),
    ._wait   (_wait),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
`ifdef Z80IO_IRQ_EN
    ,
    ._int    (_int)
`endif
  );

  // clock / reset
  initial begin
    eclk = 1'b0;
    forever #5 eclk = ~eclk;
  end

  // TX sink scoreboard: every accepted byte must be the oldest byte the model expects
  always @(negedge eclk) begin
    #2;
    if (!ereset && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_pop_unexpected got=%02h expected=none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          miscompares++;
          $display("FAIL tx_pop_data got=%02h expected=%02h", tx_data, mon_exp);
        end
      end
    end
  end

  // driver: one complete IN/OUT bus cycle, returns read data and _wait-low cycle count
  task automatic io_cycle(input bit is_read, input logic [7:0] port, input logic [7:0] wdata,
                          input int ready_after, output logic [7:0] rdata, output int wait_lo);
    bit done;
    done    = 1'b0;
    wait_lo = 0;
    rdata   = 8'hxx;
    @(negedge eclk);
    ab    = {8'($urandom_range(0, 255)), port};
    db_o  = wdata;
    _m1   = 1'b1;
    _iorq = 1'b0;
    _rd   = !is_read;
    _wr   = is_read;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge eclk);
      if (_wait === 1'b0) begin
        wait_lo++;
        if (wait_lo == ready_after) tx_ready = 1'b1;
      end else if (wait_lo > 0) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL io_timeout port=%02h wait_lo=%0d", port, wait_lo);
    end
    rdata = db_i;
    if (is_read) begin
      vectors++;
      if (db_oe !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_db_oe got=%b expected=1", db_oe);
      end
    end
    _iorq = 1'b1;
    _rd   = 1'b1;
    _wr   = 1'b1;
    @(negedge eclk);
    vectors++;
    if (db_oe !== 1'b0 || _wait !== 1'b1) begin
      miscompares++;
      $display("FAIL release got db_oe=%b _wait=%b expected 0/1", db_oe, _wait);
    end
  endtask

  task automatic present_rx(input logic [7:0] b);
    @(negedge eclk);
    vectors++;
    if (rx_ready !== !model_rx_full) begin
      miscompares++;
      $display("FAIL rx_ready_before got=%b expected=%b", rx_ready, !model_rx_full);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    if (!model_rx_full) begin
      model_rx_full = 1'b1;
      model_rx      = b;
    end
    @(negedge eclk);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    vectors++;
    if (rx_ready !== !model_rx_full) begin
      miscompares++;
      $display("FAIL rx_ready_after got=%b expected=%b", rx_ready, !model_rx_full);
    end
  endtask

  task automatic drain_fifo;
    bit empty_seen;
    empty_seen = 1'b0;
    tx_ready   = 1'b1;
    for (int n = 0; n < 60 && !empty_seen; n++) begin
      @(negedge eclk);
      if (tx_valid === 1'b0) empty_seen = 1'b1;
    end
    tx_ready = 1'b0;
    vectors++;
    if (!empty_seen || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain tx_valid=%b model_left=%0d expected 0/0", tx_valid, exp_q.size());
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (db_i !== 8'h00 || db_oe !== 1'b0 || _wait !== 1'b1 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values got db_i=%02h db_oe=%b _wait=%b tx_valid=%b rx_ready=%b expected 00/0/1/0/1",
               db_i, db_oe, _wait, tx_valid, rx_ready);
    end
`ifdef Z80IO_IRQ_EN
    vectors++;
    if (_int !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_int got=%b expected=1", _int);
    end
`endif
    present_rx(8'hA5);
    // start an OUT and abandon it from inside WAIT
    @(negedge eclk);
    ab    = 16'h0010;
    db_o  = 8'h99;
    _m1   = 1'b1;
    _iorq = 1'b0;
    _wr   = 1'b0;
    @(negedge eclk);
    vectors++;
    if (_wait !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pre_wait got=%b expected=0", _wait);
    end
    #2 ereset = 1'b1;
    #1;
    vectors++;
    if (_wait !== 1'b1 || db_oe !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async got _wait=%b db_oe=%b tx_valid=%b rx_ready=%b expected 1/0/0/1",
               _wait, db_oe, tx_valid, rx_ready);
    end
    model_rx_full = 1'b0;
    model_irq     = 1'b0;
    _iorq = 1'b1;
    _wr   = 1'b1;
    repeat (10) @(negedge eclk);
    ereset = 1'b0;
    repeat (3) @(negedge eclk);
    vectors++;
    if (tx_valid !== 1'b0 || _wait !== 1'b1 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_abandon got tx_valid=%b _wait=%b rx_ready=%b expected 0/1/1",
               tx_valid, _wait, rx_ready);
    end
  endtask

  task automatic test_out_single;
    logic [7:0] rdat;
    int wl;
    tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    io_cycle(1'b0, 8'h10, 8'h41, -1, rdat, wl);
    vectors++;
    if (wl != EXP_WAIT) begin
      miscompares++;
      $display("FAIL out_wait_len got=%0d expected=%0d", wl, EXP_WAIT);
    end
    vectors++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL out_popped got tx_valid=%b left=%0d expected 0/0", tx_valid, exp_q.size());
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_fifo_full;
    logic [7:0] rdat;
    int wl;
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'(i));
      io_cycle(1'b0, 8'h10, 8'(i), -1, rdat, wl);
      vectors++;
      if (wl != EXP_WAIT) begin
        miscompares++;
        $display("FAIL fill_wait_len idx=%0d got=%0d expected=%0d", i, wl, EXP_WAIT);
      end
    end
    io_cycle(1'b1, 8'h11, 8'h00, -1, rdat, wl);
    vectors++;
    if (rdat !== {4'b0000, model_irq, 1'b0, model_rx_full, 1'b0}) begin
      miscompares++;
      $display("FAIL full_status got=%02h expected=%02h", rdat, {4'b0000, model_irq, 1'b0, model_rx_full, 1'b0});
    end
    // ninth byte stalls until the sink frees a slot, which becomes usable the next cycle
    exp_q.push_back(8'h08);
    io_cycle(1'b0, 8'h10, 8'h08, 10, rdat, wl);
    vectors++;
    if (wl != 11) begin
      miscompares++;
      $display("FAIL full_stall_len got=%0d expected=11", wl);
    end
    drain_fifo();
  endtask

  task automatic test_rx;
    logic [7:0] rdat;
    logic [7:0] exp;
    int wl;
    present_rx(8'h5A);
    exp = {4'b0000, model_irq, exp_q.size() == 0, model_rx_full, exp_q.size() < DEPTH};
    io_cycle(1'b1, 8'h11, 8'h00, -1, rdat, wl);
    vectors++;
    if (rdat !== exp) begin
      miscompares++;
      $display("FAIL rx_status got=%02h expected=%02h", rdat, exp);
    end
    io_cycle(1'b1, 8'h10, 8'h00, -1, rdat, wl);
    vectors++;
    if (rdat !== 8'h5A || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_read got=%02h rx_ready=%b expected=5a/1", rdat, rx_ready);
    end
    model_rx_full = 1'b0;
    io_cycle(1'b1, 8'h10, 8'h00, -1, rdat, wl);
    vectors++;
    if (rdat !== 8'hFF) begin
      miscompares++;
      $display("FAIL rx_read_empty got=%02h expected=ff", rdat);
    end
  endtask

  task automatic test_ignored;
    logic [7:0] rdat;
    int wl;
    int bad;
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      io_cycle(1'b0, 8'h10, 8'hC0 + 8'(i), -1, rdat, wl);
    end
    bad = 0;
    for (int phase = 0; phase < 4; phase++) begin
      @(negedge eclk);
      db_o = 8'hEE;
      case (phase)
        0: begin ab = 16'h0010; _iorq = 1'b0; _m1 = 1'b0; _rd = 1'b0; _wr = 1'b1; end
        1: begin ab = 16'h0012; _iorq = 1'b0; _m1 = 1'b1; _rd = 1'b0; _wr = 1'b1; end
        2: begin ab = 16'h0112; _iorq = 1'b0; _m1 = 1'b1; _rd = 1'b1; _wr = 1'b0; end
        default: begin ab = 16'h0010; _iorq = 1'b1; _m1 = 1'b1; _rd = 1'b1; _wr = 1'b0; end
      endcase
      repeat (6) begin
        @(negedge eclk);
        if (_wait !== 1'b1 || db_oe !== 1'b0) bad++;
      end
      _iorq = 1'b1; _m1 = 1'b1; _rd = 1'b1; _wr = 1'b1;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ignored_cycles bad_samples=%0d expected=0", bad);
    end
    drain_fifo();
  endtask

  task automatic test_back_to_back;
    logic [7:0] rdat;
    logic [7:0] d;
    int wl;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = $urandom_range(0, 255);
      exp_q.push_back(d);
      io_cycle(1'b0, 8'h10, d, -1, rdat, wl);
      vectors++;
      if (wl != EXP_WAIT) begin
        miscompares++;
        $display("FAIL b2b_wait_len idx=%0d got=%0d expected=%0d", i, wl, EXP_WAIT);
      end
    end
    drain_fifo();
  endtask

  task automatic test_flush;
    logic [7:0] rdat;
    logic [7:0] d;
    int wl;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(0, 255);
      exp_q.push_back(d);
      io_cycle(1'b0, 8'h10, d, -1, rdat, wl);
    end
    io_cycle(1'b0, 8'h11, 8'h7E, -1, rdat, wl);
    if (HAS_IRQ) model_irq = 1'b0;
    vectors++;
    if (tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ctrl_no_flush got tx_valid=%b expected=1", tx_valid);
    end
    io_cycle(1'b0, 8'h11, 8'h80, -1, rdat, wl);
    exp_q.delete();
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ctrl_flush got tx_valid=%b expected=0", tx_valid);
    end
    io_cycle(1'b1, 8'h11, 8'h00, -1, rdat, wl);
    vectors++;
    if (rdat !== {4'b0000, model_irq, 1'b1, model_rx_full, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_status got=%02h expected=%02h", rdat, {4'b0000, model_irq, 1'b1, model_rx_full, 1'b1});
    end
  endtask

`ifdef Z80IO_IRQ_EN
  task automatic test_irq;
    logic [7:0] rdat;
    int wl;
    io_cycle(1'b0, 8'h11, 8'h01, -1, rdat, wl);
    model_irq = 1'b1;
    vectors++;
    if (_int !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_idle got=%b expected=1", _int);
    end
    present_rx(8'h33);
    @(negedge eclk);
    vectors++;
    if (_int !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_assert got=%b expected=0", _int);
    end
    io_cycle(1'b1, 8'h10, 8'h00, -1, rdat, wl);
    model_rx_full = 1'b0;
    vectors++;
    if (rdat !== 8'h33 || _int !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_read got data=%02h _int=%b expected=33/1", rdat, _int);
    end
    io_cycle(1'b1, 8'h11, 8'h00, -1, rdat, wl);
    vectors++;
    if (rdat[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_status_bit got=%02h expected bit3=1", rdat);
    end
  endtask
`endif

  task automatic test_random;
    logic [7:0] rdat;
    logic [7:0] d;
    logic [7:0] exp;
    int wl;
    int op;
    tx_ready = 1'b0;
    for (int it = 0; it < 60; it++) begin
      @(negedge eclk);
`ifdef Z80IO_IRQ_EN
      vectors++;
      if (_int !== !(model_irq && model_rx_full)) begin
        miscompares++;
        $display("FAIL rand_int it=%0d got=%b expected=%b", it, _int, !(model_irq && model_rx_full));
      end
`endif
      op = $urandom_range(0, 5);
      d  = $urandom_range(0, 255);
      case (op)
        0: begin
          if (exp_q.size() == DEPTH) drain_fifo();
          exp_q.push_back(d);
          io_cycle(1'b0, 8'h10, d, -1, rdat, wl);
          vectors++;
          if (wl != EXP_WAIT) begin
            miscompares++;
            $display("FAIL rand_out_wait it=%0d got=%0d expected=%0d", it, wl, EXP_WAIT);
          end
        end
        1: begin
          exp = model_rx_full ? model_rx : 8'hFF;
          io_cycle(1'b1, 8'h10, 8'h00, -1, rdat, wl);
          model_rx_full = 1'b0;
          vectors++;
          if (rdat !== exp) begin
            miscompares++;
            $display("FAIL rand_in_data it=%0d got=%02h expected=%02h", it, rdat, exp);
          end
        end
        2: begin
          exp = {4'b0000, model_irq, exp_q.size() == 0, model_rx_full, exp_q.size() < DEPTH};
          io_cycle(1'b1, 8'h11, 8'h00, -1, rdat, wl);
          vectors++;
          if (rdat !== exp) begin
            miscompares++;
            $display("FAIL rand_in_status it=%0d got=%02h expected=%02h", it, rdat, exp);
          end
        end
        3: present_rx(d);
        4: begin
          io_cycle(1'b0, 8'h11, d, -1, rdat, wl);
          if (d[7]) exp_q.delete();
          if (HAS_IRQ) model_irq = d[0];
          vectors++;
          if (tx_valid !== (exp_q.size() != 0)) begin
            miscompares++;
            $display("FAIL rand_ctrl it=%0d got tx_valid=%b expected=%b", it, tx_valid, exp_q.size() != 0);
          end
        end
        default: drain_fifo();
      endcase
    end
    drain_fifo();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    model_rx_full = 1'b0;
    model_rx      = 8'h00;
    model_irq     = 1'b0;
    ereset   = 1'b1;
    ab       = 16'h0000;
    db_o     = 8'h00;
    _iorq    = 1'b1;
    _m1      = 1'b1;
    _rd      = 1'b1;
    _wr      = 1'b1;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge eclk);
    ereset = 1'b0;
    @(negedge eclk);

    test_reset();
    test_out_single();
    test_fifo_full();
    test_rx();
    test_ignored();
    test_back_to_back();
    test_flush();
`ifdef Z80IO_IRQ_EN
    test_irq();
`endif
    test_random();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue got=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
